// File: rtl/conv_pkg.sv
// Shared definitions for the CONV memory-side responder: widths, bank-select codes
// and the host handshake state type.
package conv_pkg;
    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 12;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_RUN,
        ST_DONE
    } host_state_e;

    // Which bank a pending registered read was issued against.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_L0,
        SRC_L1
    } rd_src_e;
endpackage

// File: rtl/sp_ram_1r1w.sv
// Synchronous RAM: one write port, one registered read port. A read and a write to
// the same address on the same edge return the previous contents.
module sp_ram_1r1w #(
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/conv_mem_host.sv
// Memory responder for the CONV accelerator: image store, layer-0/layer-1 result
// banks, ready/busy start handshake, completion detect and host readback.
module conv_mem_host #(
    parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = conv_pkg::ADDR_WIDTH,
    parameter int IMAGE_WIDTH = 64,
    parameter int L1_DEPTH    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    input  logic                  clear,
    output logic                  ready,
    input  logic                  busy,
    input  logic [ADDR_WIDTH-1:0] iaddr,
    output logic [DATA_WIDTH-1:0] idata,
    input  logic                  cwr,
    input  logic [ADDR_WIDTH-1:0] caddr_wr,
    input  logic [DATA_WIDTH-1:0] cdata_wr,
    input  logic                  crd,
    input  logic [ADDR_WIDTH-1:0] caddr_rd,
    output logic [DATA_WIDTH-1:0] cdata_rd,
    input  logic [2:0]            csel,
    input  logic                  host_rd,
    input  logic                  host_sel,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   l0_wr_cnt
);
    import conv_pkg::*;

    localparam int IMG_DEPTH = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int L1_AW     = $clog2(L1_DEPTH);
    localparam logic [ADDR_WIDTH:0] L1_LIM  = (ADDR_WIDTH+1)'(L1_DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(IMG_DEPTH);

    host_state_e state_q, state_d;
    logic        in_idle, in_run, in_done;

    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  crd_pend_q, crd_pend_d;
    rd_src_e               crd_src_q, crd_src_d;
    logic                  host_pend_q, host_pend_d;
    rd_src_e               host_src_q, host_src_d;
    logic [DATA_WIDTH-1:0] cdata_hold_q, cdata_hold_d;
    logic [DATA_WIDTH-1:0] host_hold_q, host_hold_d;
    logic                  idata_vld_q, idata_vld_d;

    logic                  l1_wr_ok, l1_rd_ok, l1_host_ok;
    logic                  img_we, l0_we, l1_we, l0_re, l1_re;
    logic                  crd_go, host_go, err_set;
    logic [ADDR_WIDTH-1:0] port_addr;
    logic [L1_AW-1:0]      l1_waddr, l1_raddr;
    logic [DATA_WIDTH-1:0] img_rdata, l0_rdata, l1_rdata;

    function automatic logic [DATA_WIDTH-1:0] pick_bank(input rd_src_e src,
                                                        input logic [DATA_WIDTH-1:0] l0,
                                                        input logic [DATA_WIDTH-1:0] l1);
        case (src)
            SRC_L0:  return l0;
            SRC_L1:  return l1;
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_done)        state_d = ST_READY;
            ST_READY: if (busy)             state_d = ST_RUN;
            ST_RUN:   if (busy_q && !busy)  state_d = ST_DONE;
            ST_DONE:  if (clear)            state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state_q == ST_READY);
        done    = (state_q == ST_DONE);
        in_idle = (state_q == ST_IDLE);
        in_run  = (state_q == ST_RUN);
        in_done = (state_q == ST_DONE);
    end

    // Bank port arbitration: in DONE the host owns each bank's read port.
    always_comb begin
        l1_wr_ok   = {1'b0, caddr_wr}  < L1_LIM;
        l1_rd_ok   = {1'b0, caddr_rd}  < L1_LIM;
        l1_host_ok = {1'b0, host_addr} < L1_LIM;
        img_we     = load_valid & in_idle;
        l0_we      = cwr & in_run & (csel == CSEL_L0);
        l1_we      = cwr & in_run & (csel == CSEL_L1) & l1_wr_ok;
        crd_go     = crd & in_run;
        host_go    = host_rd & in_done;
        port_addr  = host_go ? host_addr : caddr_rd;
        l1_waddr   = caddr_wr[L1_AW-1:0];
        l1_raddr   = port_addr[L1_AW-1:0];
        l0_re      = host_go ? ~host_sel : (crd_go & (csel == CSEL_L0));
        l1_re      = host_go ? (host_sel & l1_host_ok)
                             : (crd_go & (csel == CSEL_L1) & l1_rd_ok);

        crd_pend_d = crd_go;
        crd_src_d  = SRC_NONE;
        if (csel == CSEL_L0) begin
            crd_src_d = SRC_L0;
        end else if (csel == CSEL_L1 && l1_rd_ok) begin
            crd_src_d = SRC_L1;
        end
        host_pend_d = host_go;
        host_src_d  = host_sel ? (l1_host_ok ? SRC_L1 : SRC_NONE) : SRC_L0;

        err_set = (load_valid & ~in_idle)
                | (cwr & (csel != CSEL_L0) & (csel != CSEL_L1))
                | ((cwr | crd) & ~in_run)
                | (cwr & (csel == CSEL_L1) & ~l1_wr_ok)
                | (crd & (csel == CSEL_L1) & ~l1_rd_ok);
        err_d = clear ? 1'b0 : (err_q | err_set);

        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (l0_we && cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d      = busy;
        idata_vld_d = 1'b1;
    end

    // Read outputs follow the bank port on the cycle after a strobe, else hold.
    always_comb begin
        idata        = idata_vld_q ? img_rdata : '0;
        cdata_rd     = crd_pend_q ? pick_bank(crd_src_q, l0_rdata, l1_rdata) : cdata_hold_q;
        host_rdata   = host_pend_q ? pick_bank(host_src_q, l0_rdata, l1_rdata) : host_hold_q;
        cdata_hold_d = cdata_rd;
        host_hold_d  = host_rdata;
        err          = err_q;
        l0_wr_cnt    = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            crd_pend_q   <= 1'b0;
            crd_src_q    <= SRC_NONE;
            host_pend_q  <= 1'b0;
            host_src_q   <= SRC_NONE;
            cdata_hold_q <= '0;
            host_hold_q  <= '0;
            idata_vld_q  <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            crd_pend_q   <= crd_pend_d;
            crd_src_q    <= crd_src_d;
            host_pend_q  <= host_pend_d;
            host_src_q   <= host_src_d;
            cdata_hold_q <= cdata_hold_d;
            host_hold_q  <= host_hold_d;
            idata_vld_q  <= idata_vld_d;
        end
    end

    sp_ram_1r1w #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(IMG_DEPTH)) u_img (
        .clk(clk), .we(img_we), .waddr(load_addr), .wdata(load_data),
        .re(1'b1), .raddr(iaddr), .rdata(img_rdata)
    );

    sp_ram_1r1w #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(IMG_DEPTH)) u_l0 (
        .clk(clk), .we(l0_we), .waddr(caddr_wr), .wdata(cdata_wr),
        .re(l0_re), .raddr(port_addr), .rdata(l0_rdata)
    );

    sp_ram_1r1w #(.DW(DATA_WIDTH), .AW(L1_AW), .DEPTH(L1_DEPTH)) u_l1 (
        .clk(clk), .we(l1_we), .waddr(l1_waddr), .wdata(cdata_wr),
        .re(l1_re), .raddr(l1_raddr), .rdata(l1_rdata)
    );
endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: a behavioural memory/handshake model checked every
// cycle, plus literal expectations at the key points of the sequence.
module tb_conv_mem_host;
    localparam int DW = 20;
    localparam int AW = 12;
    localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 0, load_done = 0, clear = 0, busy = 0;
    logic [AW-1:0] load_addr = '0, iaddr = '0, caddr_wr = '0, caddr_rd = '0, host_addr = '0;
    logic [DW-1:0] load_data = '0, cdata_wr = '0;
    logic          cwr = 0, crd = 0, host_rd = 0, host_sel = 0;
    logic [2:0]    csel = 3'b000;
    logic          ready, done, err;
    logic [DW-1:0] idata, cdata_rd, host_rdata;
    logic [AW:0]   l0_wr_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    conv_mem_host dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
        .load_data(load_data), .load_done(load_done), .clear(clear), .ready(ready),
        .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .host_rd(host_rd), .host_sel(host_sel), .host_addr(host_addr),
        .host_rdata(host_rdata), .done(done), .err(err), .l0_wr_cnt(l0_wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: banks as arrays with known-bits, mode as a plain integer.
    logic [DW-1:0] img_m [4096];
    logic [DW-1:0] l0_m  [4096];
    logic [DW-1:0] l1_m  [1024];
    bit            img_k [4096];
    bit            l0_k  [4096];
    bit            l1_k  [1024];
    int            m_mode = M_IDLE;
    bit            m_prev_busy = 0, m_err = 0, chk_en = 0;
    int            m_cnt = 0;
    logic [DW-1:0] ex_idata = '0, ex_cd = '0, ex_host = '0;
    bit            k_idata = 0, k_cd = 0, k_host = 0;

    always @(posedge clk) begin
        bit bad;
        bit l0_wr;
        if (!reset) begin
            m_mode = M_IDLE; m_prev_busy = 0; m_err = 0; m_cnt = 0;
            ex_idata = '0; ex_cd = '0; ex_host = '0;
            k_idata = 1; k_cd = 1; k_host = 1; chk_en = 1;
        end else begin
            ex_idata = img_m[iaddr]; k_idata = img_k[iaddr];
            if (m_mode == M_RUN && crd) begin
                if (csel == 3'b001) begin
                    ex_cd = l0_m[caddr_rd]; k_cd = l0_k[caddr_rd];
                end else if (csel == 3'b011 && caddr_rd < 1024) begin
                    ex_cd = l1_m[caddr_rd[9:0]]; k_cd = l1_k[caddr_rd[9:0]];
                end else begin
                    ex_cd = '0; k_cd = 1;
                end
            end
            if (m_mode == M_DONE && host_rd) begin
                if (!host_sel) begin
                    ex_host = l0_m[host_addr]; k_host = l0_k[host_addr];
                end else if (host_addr < 1024) begin
                    ex_host = l1_m[host_addr[9:0]]; k_host = l1_k[host_addr[9:0]];
                end else begin
                    ex_host = '0; k_host = 1;
                end
            end
            bad = (load_valid && m_mode != M_IDLE)
               || (cwr && csel != 3'b001 && csel != 3'b011)
               || ((cwr || crd) && m_mode != M_RUN)
               || (cwr && csel == 3'b011 && caddr_wr >= 1024)
               || (crd && csel == 3'b011 && caddr_rd >= 1024);
            if (load_valid && m_mode == M_IDLE) begin
                img_m[load_addr] = load_data; img_k[load_addr] = 1;
            end
            l0_wr = cwr && m_mode == M_RUN && csel == 3'b001;
            if (l0_wr) begin
                l0_m[caddr_wr] = cdata_wr; l0_k[caddr_wr] = 1;
            end
            if (cwr && m_mode == M_RUN && csel == 3'b011 && caddr_wr < 1024) begin
                l1_m[caddr_wr[9:0]] = cdata_wr; l1_k[caddr_wr[9:0]] = 1;
            end
            if (clear) begin
                m_err = 0; m_cnt = 0;
            end else begin
                m_err = m_err | bad;
                if (l0_wr && m_cnt < 4096) m_cnt++;
            end
            case (m_mode)
                M_IDLE:  if (load_done) m_mode = M_READY;
                M_READY: if (busy) m_mode = M_RUN;
                M_RUN:   if (m_prev_busy && !busy) m_mode = M_DONE;
                default: if (clear) m_mode = M_IDLE;
            endcase
            m_prev_busy = busy;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'b0, ready}, {31'b0, m_mode == M_READY});
            check("done", {31'b0, done}, {31'b0, m_mode == M_DONE});
            check("err", {31'b0, err}, {31'b0, m_err});
            check("l0_wr_cnt", 32'(l0_wr_cnt), 32'(m_cnt));
            if (k_idata) check("idata", 32'(idata), 32'(ex_idata));
            if (k_cd)    check("cdata_rd", 32'(cdata_rd), 32'(ex_cd));
            if (k_host)  check("host_rdata", 32'(host_rdata), 32'(ex_host));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobes_off();
        load_valid = 0; load_done = 0; clear = 0; cwr = 0; crd = 0; host_rd = 0;
    endtask

    task automatic lwrite(input logic [2:0] sel, input int addr, input logic [DW-1:0] data);
        cwr = 1; csel = sel; caddr_wr = AW'(addr); cdata_wr = data;
        tick();
        cwr = 0;
    endtask

    task automatic lread(input logic [2:0] sel, input int addr);
        crd = 1; csel = sel; caddr_rd = AW'(addr);
        tick();
        crd = 0;
    endtask

    initial begin
        tick(); tick();
        reset = 1;
        tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_cnt", 32'(l0_wr_cnt), 32'd0);
        check("rst_cdata", 32'(cdata_rd), 32'd0);

        for (int i = 0; i < 4096; i++) begin
            load_valid = 1; load_addr = AW'(i); load_data = DW'(i);
            tick();
        end
        load_valid = 0;
        load_done = 1; tick(); load_done = 0;
        check("ready_after_load", {31'b0, ready}, 32'd1);
        iaddr = 12'd100; tick();
        check("idata_100", 32'(idata), 32'd100);
        iaddr = 12'd4095; tick();
        check("idata_4095", 32'(idata), 32'd4095);

        busy = 1; tick();
        check("ready_fall", {31'b0, ready}, 32'd0);

        lwrite(3'b011, 7, 20'd3);
        lwrite(3'b001, 5, 20'h12345);
        lread(3'b001, 5);
        check("l0_rd_5", 32'(cdata_rd), 32'h12345);
        check("cnt_1", 32'(l0_wr_cnt), 32'd1);

        cwr = 1; crd = 1; csel = 3'b011; caddr_wr = 12'd7; cdata_wr = 20'd9; caddr_rd = 12'd7;
        tick();
        cwr = 0;
        check("rbw_old", 32'(cdata_rd), 32'd3);
        tick();
        crd = 0;
        check("rbw_new", 32'(cdata_rd), 32'd9);

        lread(3'b000, 5);
        check("csel_none_rd", 32'(cdata_rd), 32'd0);
        check("err_clean", {31'b0, err}, 32'd0);
        lwrite(3'b010, 5, 20'hBAD);
        check("err_bad_csel", {31'b0, err}, 32'd1);
        lread(3'b001, 5);
        check("l0_untouched", 32'(cdata_rd), 32'h12345);
        check("err_sticky", {31'b0, err}, 32'd1);

        clear = 1; tick(); clear = 0;
        check("err_cleared", {31'b0, err}, 32'd0);
        lwrite(3'b011, 0, 20'h11);
        lwrite(3'b011, 1024, 20'h55);
        check("err_l1_oob", {31'b0, err}, 32'd1);
        lread(3'b011, 0);
        check("l1_oob_dropped", 32'(cdata_rd), 32'h11);

        for (int i = 0; i < 4100; i++) begin
            cwr = 1; csel = 3'b001; caddr_wr = AW'(i);
            cdata_wr = (i % 4096 == 5) ? 20'h12345 : DW'(i);
            tick();
        end
        cwr = 0;
        check("cnt_sat", 32'(l0_wr_cnt), 32'd4096);

        busy = 0; tick();
        check("done_rise", {31'b0, done}, 32'd1);
        host_rd = 1; host_sel = 0; host_addr = 12'd5;
        crd = 1; csel = 3'b001; caddr_rd = 12'd6;
        tick();
        strobes_off();
        check("host_l0_5", 32'(host_rdata), 32'h12345);
        check("crd_ignored", 32'(cdata_rd), 32'h11);
        host_rd = 1; host_sel = 1; host_addr = 12'd7; tick(); host_rd = 0;
        check("host_l1_7", 32'(host_rdata), 32'd9);
        clear = 1; tick(); clear = 0;
        check("clear_done", {31'b0, done}, 32'd0);
        check("clear_cnt", 32'(l0_wr_cnt), 32'd0);
        check("clear_err", {31'b0, err}, 32'd0);

        load_done = 1; tick(); load_done = 0;
        busy = 1; tick();
        lread(3'b001, 5);
        check("pre_rst_cdata", 32'(cdata_rd), 32'h12345);
        lwrite(3'b010, 0, 20'h1);
        check("pre_rst_err", {31'b0, err}, 32'd1);
        reset = 0; tick(); busy = 0; reset = 1;
        check("mid_rst_ready", {31'b0, ready}, 32'd0);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        check("mid_rst_cdata", 32'(cdata_rd), 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        load_done = 1; tick(); load_done = 0;
        check("idle_after_rst", {31'b0, ready}, 32'd1);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
